uart_rx_os16: RTL and testbench



---
 rtl/uart_rx_os16.sv | 90 +++++++++
 tb/tb_uart_rx_os16.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 8N1-style UART receiver sampling a 16x oversampling tick; bits are taken at
// their centres after a two-flop synchroniser on the serial line.
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err
);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [3:0]             s;
  logic [NW-1:0]          n;
  logic [DATA_BITS-1:0]   shift;
  logic [1:0]             sync_q;
  logic                   rx_s;

  assign rx_s = sync_q[1];

  // Synchroniser resets to the idle level so release never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], i_rx};
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      s           <= '0;
      n           <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        // Level-sensitive: a held-low line restarts a frame straight away.
        IDLE: if (!rx_s) begin
          state <= START;
          s     <= '0;
        end
        START: if (i_tick) begin
          if (s == 4'd7) begin
            if (!rx_s) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            s <= s + 4'd1;
          end
        end
        DATA: if (i_tick) begin
          if (s == 4'd15) begin
            s     <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (n == N_LAST) state <= STOP;
            else             n     <= n + 1'b1;
          end else begin
            s <= s + 4'd1;
          end
        end
        STOP: if (i_tick) begin
          if (s == STOP_LAST) begin
            o_data      <= shift;
            o_rx_done   <= 1'b1;
            o_frame_err <= ~rx_s;
            state       <= IDLE;
          end else begin
            s <= s + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: drives serial frames at 16 ticks per bit, one tick
// every 4 clocks, and checks each delivered byte against the frame it sent.
module tb_uart_rx_os16;
  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int consec = 0;
  logic prev_done = 1'b0;

  logic [7:0] dq[$];
  logic       eq[$];
  int         tq[$];

  uart_rx_os16 #(.DATA_BITS(8), .STOP_TICKS(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_rx(i_rx),
    .o_data(o_data), .o_rx_done(o_rx_done), .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  initial forever begin
    repeat (3) @(negedge i_clk);
    i_tick = 1'b1;
    tick_cnt++;
    @(negedge i_clk);
    i_tick = 1'b0;
  end

  // Record every done pulse with the payload seen alongside it.
  initial forever begin
    @(negedge i_clk);
    if (i_reset) begin
      if (o_rx_done) begin
        dq.push_back(o_data);
        eq.push_back(o_frame_err);
        tq.push_back(tick_cnt);
        if (prev_done) consec++;
      end
      prev_done = o_rx_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_ticks(input int k);
    repeat (k) @(posedge i_clk iff i_tick);
    #1;
  endtask

  task automatic clear_q();
    dq.delete(); eq.delete(); tq.delete();
  endtask

  // A zero stop bit is held only past its centre so the line is idle again afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    i_rx = 1'b0; wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i]; wait_ticks(16);
    end
    if (stop) begin
      i_rx = 1'b1; wait_ticks(16);
    end else begin
      i_rx = 1'b0; wait_ticks(9);
      i_rx = 1'b1; wait_ticks(7);
    end
    i_rx = 1'b1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (5) @(negedge i_clk);
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", o_data); end
    checks++; if (o_rx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_rx_done); end
    checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", o_frame_err); end
    i_reset = 1'b1;
    wait_ticks(10);
    checks++; if (dq.size() !== 0) begin failures++; $display("FAIL idle_after_reset got=%0d exp=0", dq.size()); end
  endtask

  task automatic test_valid();
    clear_q();
    send_frame(8'hA5, 1'b1);
    wait_ticks(2);
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL valid_count got=%0d exp=1", dq.size()); end
    if (dq.size() > 0) begin
      checks++; if (dq[0] !== 8'hA5) begin failures++; $display("FAIL valid_data got=%h exp=a5", dq[0]); end
      checks++; if (eq[0] !== 1'b0) begin failures++; $display("FAIL valid_err got=%b exp=0", eq[0]); end
    end
    wait_ticks(60);
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL valid_extra got=%0d exp=1", dq.size()); end
    checks++; if (o_data !== 8'hA5) begin failures++; $display("FAIL valid_hold got=%h exp=a5", o_data); end
  endtask

  task automatic test_glitch();
    clear_q();
    i_rx = 1'b0; wait_ticks(4);
    i_rx = 1'b1; wait_ticks(200);
    checks++; if (dq.size() !== 0) begin failures++; $display("FAIL glitch_done got=%0d exp=0", dq.size()); end
    send_frame(8'h5A, 1'b1);
    wait_ticks(2);
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL glitch_next_count got=%0d exp=1", dq.size()); end
    if (dq.size() > 0) begin
      checks++; if (dq[0] !== 8'h5A) begin failures++; $display("FAIL glitch_next_data got=%h exp=5a", dq[0]); end
    end
  endtask

  task automatic test_frame_err();
    clear_q();
    send_frame(8'h3C, 1'b0);
    wait_ticks(5);
    send_frame(8'hC3, 1'b1);
    wait_ticks(2);
    checks++; if (dq.size() !== 2) begin failures++; $display("FAIL ferr_count got=%0d exp=2", dq.size()); end
    if (dq.size() > 1) begin
      checks++; if (dq[0] !== 8'h3C) begin failures++; $display("FAIL ferr_data got=%h exp=3c", dq[0]); end
      checks++; if (eq[0] !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", eq[0]); end
      checks++; if (dq[1] !== 8'hC3) begin failures++; $display("FAIL ferr_next_data got=%h exp=c3", dq[1]); end
      checks++; if (eq[1] !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", eq[1]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(2);
    checks++; if (dq.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", dq.size()); end
    if (dq.size() > 1) begin
      checks++; if (dq[0] !== 8'h00) begin failures++; $display("FAIL b2b_data0 got=%h exp=00", dq[0]); end
      checks++; if (dq[1] !== 8'hFF) begin failures++; $display("FAIL b2b_data1 got=%h exp=ff", dq[1]); end
      checks++; if ((eq[0] | eq[1]) !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b%b exp=00", eq[0], eq[1]); end
      checks++; if (tq[1] - tq[0] !== 160) begin failures++; $display("FAIL b2b_spacing got=%0d exp=160", tq[1] - tq[0]); end
    end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    i_rx = 1'b0; wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      i_rx = (i == 0) ? 1'b1 : 1'b0; wait_ticks(16);
    end
    i_reset = 1'b0;
    #1;
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL midreset_data got=%h exp=00", o_data); end
    i_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    wait_ticks(200);
    checks++; if (dq.size() !== 0) begin failures++; $display("FAIL midreset_done got=%0d exp=0", dq.size()); end
    send_frame(8'h7E, 1'b1);
    wait_ticks(2);
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL midreset_next_count got=%0d exp=1", dq.size()); end
    if (dq.size() > 0) begin
      checks++; if (dq[0] !== 8'h7E) begin failures++; $display("FAIL midreset_next_data got=%h exp=7e", dq[0]); end
    end
  endtask

  task automatic test_break();
    clear_q();
    i_rx = 1'b0; wait_ticks(480);
    i_rx = 1'b1;
    checks++; if (dq.size() !== 3) begin failures++; $display("FAIL break_count got=%0d exp=3", dq.size()); end
    for (int i = 0; i < dq.size(); i++) begin
      checks++; if (dq[i] !== 8'h00 || eq[i] !== 1'b1) begin
        failures++; $display("FAIL break_frame%0d got=%h/%b exp=00/1", i, dq[i], eq[i]);
      end
    end
    wait_ticks(300);
    clear_q();
    send_frame(8'h33, 1'b1);
    wait_ticks(2);
    checks++; if (dq.size() !== 1) begin failures++; $display("FAIL break_recover_count got=%0d exp=1", dq.size()); end
    if (dq.size() > 0) begin
      checks++; if (dq[0] !== 8'h33 || eq[0] !== 1'b0) begin
        failures++; $display("FAIL break_recover got=%h/%b exp=33/0", dq[0], eq[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       st;
    for (int f = 0; f < 12; f++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      clear_q();
      send_frame(b, st);
      wait_ticks(2);
      checks++; if (dq.size() !== 1) begin
        failures++; $display("FAIL rand%0d_count got=%0d exp=1", f, dq.size());
      end else begin
        checks++; if (dq[0] !== b || eq[0] !== ~st) begin
          failures++; $display("FAIL rand%0d got=%h/%b exp=%h/%b", f, dq[0], eq[0], b, ~st);
        end
      end
      wait_ticks($urandom_range(2, 20));
    end
  endtask

  task automatic test_pulse_width();
    checks++; if (consec !== 0) begin failures++; $display("FAIL done_consecutive got=%0d exp=0", consec); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_break();
    test_random();
    test_pulse_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
